// File: rtl/win_pkg.sv
// Shared constants, coordinate width helpers and pixel type for the 3x3 window generator.
// The optional start-of-frame input is enabled by defining WIN3X3_SOF_EN.
package win_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  function automatic int col_width(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int row_width(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

endpackage

// File: rtl/win3x3_if.sv
// Pixel stream in, 3x3 window out; the sof signal exists only when WIN3X3_SOF_EN is defined.
interface win3x3_if
  import win_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_pix;
`ifdef WIN3X3_SOF_EN
  logic                  sof;
`endif
  logic [DATA_WIDTH-1:0] w00, w01, w02;
  logic [DATA_WIDTH-1:0] w10, w11, w12;
  logic [DATA_WIDTH-1:0] w20, w21, w22;
  logic                  out_valid;

  modport master (
    output in_valid, in_pix,
`ifdef WIN3X3_SOF_EN
    output sof,
`endif
    input  w00, w01, w02, w10, w11, w12, w20, w21, w22, out_valid
  );

  modport slave (
    input  in_valid, in_pix,
`ifdef WIN3X3_SOF_EN
    input  sof,
`endif
    output w00, w01, w02, w10, w11, w12, w20, w21, w22, out_valid
  );

endinterface

// File: rtl/win_line_buf.sv
// Circular delay line of DEPTH entries: the output is the value written DEPTH enabled cycles ago.
// Storage is deliberately not reset; only the shared read/write pointer is.
module win_line_buf
  import win_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_IMG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PTR_W = col_width(DEPTH);

  logic [PTR_W-1:0]      ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  // Read-before-write: the entry about to be overwritten is the delayed sample.
  assign dout = mem[ptr];

endmodule

// File: rtl/win3x3.sv
// Streaming 3x3 neighbourhood generator built from two chained line buffers and a 3x3 shift window.
// Define WIN3X3_SOF_EN to add a sof input that restarts the frame counters.
module win3x3
  import win_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input logic     clk,
  input logic     rst_n,
  win3x3_if.slave bus
);

  localparam int CW = col_width(IMG_WIDTH);
  localparam int RW = row_width(IMG_HEIGHT);

  logic [CW-1:0]         col, cur_col;
  logic [RW-1:0]         row, cur_row;
  logic                  accept, restart, vld;
  logic [DATA_WIDTH-1:0] lb0_q, lb1_q;
  logic [DATA_WIDTH-1:0] win [3][3];

  assign accept = bus.in_valid;
`ifdef WIN3X3_SOF_EN
  assign restart = bus.in_valid && bus.sof;
`else
  assign restart = 1'b0;
`endif

  // A sof pixel is treated as (0,0) regardless of where the counters were.
  assign cur_col = restart ? '0 : col;
  assign cur_row = restart ? '0 : row;

  win_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en(accept), .din(bus.in_pix), .dout(lb0_q)
  );

  win_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(accept), .din(lb0_q), .dout(lb1_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      vld <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (accept) begin
        vld <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        if (cur_col == CW'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  // Row 0 is the oldest line, column 2 the newest pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_q;
      win[1][2] <= lb0_q;
      win[2][2] <= bus.in_pix;
    end
  end

  assign bus.w00 = win[0][0];
  assign bus.w01 = win[0][1];
  assign bus.w02 = win[0][2];
  assign bus.w10 = win[1][0];
  assign bus.w11 = win[1][1];
  assign bus.w12 = win[1][2];
  assign bus.w20 = win[2][0];
  assign bus.w21 = win[2][1];
  assign bus.w22 = win[2][2];
  assign bus.out_valid = vld;

endmodule

// File: tb/tb_win3x3.sv
// Self-checking bench for win3x3 on a 4x4 image with 10-bit pixels, against a frame-array model.
// Define WIN3X3_SOF_EN to also exercise the start-of-frame restart.
module tb_win3x3;
  import win_pkg::*;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef logic [8:0][DW-1:0] win_t;

  logic clk;
  logic rst_n;
  int   cmp;
  int   errs;

  logic [DW-1:0] img [H][W];
  int            mr;
  int            mc;

  win3x3_if #(.DATA_WIDTH(DW)) bus ();

  win3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic win_t obs();
    win_t w;
    w[0] = bus.w00; w[1] = bus.w01; w[2] = bus.w02;
    w[3] = bus.w10; w[4] = bus.w11; w[5] = bus.w12;
    w[6] = bus.w20; w[7] = bus.w21; w[8] = bus.w22;
    return w;
  endfunction

  function automatic win_t raster_win(input int b);
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r*3+c] = DW'(b + r*W + c);
    return w;
  endfunction

  function automatic win_t const_win(input logic [DW-1:0] v);
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = v;
    return w;
  endfunction

  // Drive one accepted pixel and compute from the frame model what must appear after the edge.
  task automatic send(input logic [DW-1:0] p, input bit s, output bit ev, output win_t ew);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
`ifdef WIN3X3_SOF_EN
    bus.sof      = s;
`endif
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
    ev = (mr >= 2) && (mc >= 2);
    ew = '0;
    if (ev)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          ew[r*3+c] = img[mr-2+r][mc-2+c];
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
`ifdef WIN3X3_SOF_EN
    bus.sof      = 1'b0;
`endif
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    cmp++;
    if (bus.out_valid !== 1'b0) begin
      errs++;
      $display("[TB] FAIL reset_valid got %b expected 0", bus.out_valid);
    end
    cmp++;
    if (obs() !== '0) begin
      errs++;
      $display("[TB] FAIL reset_window got %h expected 0", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
  endtask

  task automatic test_continuous();
    bit   ev;
    win_t ew;
    int   nwin = 0;
    for (int i = 0; i < W*H; i++) begin
      send(DW'(i), 1'b0, ev, ew);
      cmp++;
      if (bus.out_valid !== ev) begin
        errs++;
        $display("[TB] FAIL cont_valid px=%0d got %b expected %b", i, bus.out_valid, ev);
      end
      if (ev) begin
        cmp++;
        if (obs() !== ew) begin
          errs++;
          $display("[TB] FAIL cont_window px=%0d got %h expected %h", i, obs(), ew);
        end
        nwin++;
      end
      if (i == 10) begin
        cmp++;
        if (bus.out_valid !== 1'b1 || obs() !== raster_win(0)) begin
          errs++;
          $display("[TB] FAIL cont_first v=%b got %h expected %h", bus.out_valid, obs(), raster_win(0));
        end
      end
      if (i == 15) begin
        cmp++;
        if (bus.out_valid !== 1'b1 || obs() !== raster_win(5)) begin
          errs++;
          $display("[TB] FAIL cont_last v=%b got %h expected %h", bus.out_valid, obs(), raster_win(5));
        end
      end
    end
    cmp++;
    if (nwin != 4) begin
      errs++;
      $display("[TB] FAIL cont_count got %0d expected 4", nwin);
    end
  endtask

  task automatic test_gaps();
    bit   ev;
    win_t ew;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W*H; i++) begin
        int gap = $urandom_range(5, 0);
        for (int g = 0; g < gap; g++) begin
          idle_cycle();
          cmp++;
          if (bus.out_valid !== 1'b0) begin
            errs++;
            $display("[TB] FAIL gap_idle_valid got %b expected 0", bus.out_valid);
          end
        end
        send((f == 0) ? DW'(i) : DW'($urandom), 1'b0, ev, ew);
        cmp++;
        if (bus.out_valid !== ev || (ev && obs() !== ew)) begin
          errs++;
          $display("[TB] FAIL gap_window f=%0d px=%0d v=%b/%b got %h expected %h",
                   f, i, bus.out_valid, ev, obs(), ew);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit   ev;
    win_t ew;
    int   nwin = 0;
    for (int i = 0; i <= 6; i++) send(DW'(i), 1'b0, ev, ew);
    #2;
    rst_n = 1'b0;
    #1;
    cmp++;
    if (bus.out_valid !== 1'b0 || obs() !== '0) begin
      errs++;
      $display("[TB] FAIL midreset_async v=%b got %h expected 0", bus.out_valid, obs());
    end
    mr = 0;
    mc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      send(DW'(i), 1'b0, ev, ew);
      cmp++;
      if (bus.out_valid !== ev || (ev && obs() !== ew)) begin
        errs++;
        $display("[TB] FAIL midreset_window px=%0d v=%b/%b got %h expected %h",
                 i, bus.out_valid, ev, obs(), ew);
      end
      if (ev) nwin++;
    end
    cmp++;
    if (nwin != 4) begin
      errs++;
      $display("[TB] FAIL midreset_count got %0d expected 4", nwin);
    end
  endtask

  task automatic test_back_to_back();
    bit   ev;
    win_t ew;
    int   nwin [2];
    int   first2 = -1;
    nwin[0] = 0;
    nwin[1] = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      int f = i / (W*H);
      int k = i % (W*H);
      send((f == 0) ? DW'(k) : DW'(100 + k), 1'b0, ev, ew);
      cmp++;
      if (bus.out_valid !== ev || (ev && obs() !== ew)) begin
        errs++;
        $display("[TB] FAIL b2b_window f=%0d px=%0d v=%b/%b got %h expected %h",
                 f, k, bus.out_valid, ev, obs(), ew);
      end
      if (bus.out_valid === 1'b1) begin
        nwin[f]++;
        if (f == 1 && first2 < 0) begin
          first2 = k;
          cmp++;
          if (obs() !== raster_win(100)) begin
            errs++;
            $display("[TB] FAIL b2b_first2 got %h expected %h", obs(), raster_win(100));
          end
        end
      end
    end
    cmp++;
    if (first2 != 10 || nwin[0] != 4 || nwin[1] != 4) begin
      errs++;
      $display("[TB] FAIL b2b_counts first=%0d n0=%0d n1=%0d expected 10/4/4", first2, nwin[0], nwin[1]);
    end
  endtask

`ifdef WIN3X3_SOF_EN
  task automatic test_sof();
    bit   ev;
    win_t ew;
    int   first = -1;
    for (int i = 0; i < 5; i++) send(DW'(i), 1'b0, ev, ew);
    for (int k = 0; k < W*H; k++) begin
      send(DW'(200 + k), (k == 0), ev, ew);
      cmp++;
      if (bus.out_valid !== ev || (ev && obs() !== ew)) begin
        errs++;
        $display("[TB] FAIL sof_window k=%0d v=%b/%b got %h expected %h",
                 k, bus.out_valid, ev, obs(), ew);
      end
      if (bus.out_valid === 1'b1 && first < 0) begin
        first = k;
        cmp++;
        if (obs() !== raster_win(200)) begin
          errs++;
          $display("[TB] FAIL sof_first got %h expected %h", obs(), raster_win(200));
        end
      end
    end
    cmp++;
    if (first != 10) begin
      errs++;
      $display("[TB] FAIL sof_first_index got %0d expected 10", first);
    end
  endtask
`endif

  task automatic test_max_value();
    bit   ev;
    win_t ew;
    int   nwin = 0;
    for (int i = 0; i < W*H; i++) begin
      send(DW'(1023), 1'b0, ev, ew);
      cmp++;
      if (bus.out_valid !== ev) begin
        errs++;
        $display("[TB] FAIL max_valid px=%0d got %b expected %b", i, bus.out_valid, ev);
      end
      if (bus.out_valid === 1'b1) begin
        nwin++;
        cmp++;
        if (obs() !== const_win(DW'(1023))) begin
          errs++;
          $display("[TB] FAIL max_window px=%0d got %h expected all 3ff", i, obs());
        end
      end
    end
    cmp++;
    if (nwin != 4) begin
      errs++;
      $display("[TB] FAIL max_count got %0d expected 4", nwin);
    end
  endtask

  initial begin
    cmp = 0;
    errs = 0;
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;
`ifdef WIN3X3_SOF_EN
    bus.sof      = 1'b0;
`endif
    test_reset();
    test_continuous();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
`ifdef WIN3X3_SOF_EN
    test_sof();
`endif
    test_max_value();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
